// File: rtl/dec_is_queue.sv
// dec_is_queue: decoupling instruction queue between decode and issue.
// Buffers decoded instructions so decode keeps running while issue stalls,
// tags every accepted instruction with a wrapping sequence number, and is
// emptied by a pipeline flush.
//
// Ports:
//   clk, reset_           rising-edge clock, async active-low reset
//   flush                 drop all entries (dominates enq/deq)
//   dec_valid/dec_ready   decode-side handshake; dec_pc/dec_uop/dec_br_tk payload
//   is_valid/is_ready     issue-side handshake; is_pc/is_uop/is_br_tk/is_seq head
//   count                 current occupancy (0..DEPTH)
module dec_is_queue #(
    parameter int ADDR  = 32,
    parameter int UOP   = 64,
    parameter int DEPTH = 8,
    parameter int SEQ_W = 6,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             flush,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [ADDR-1:0]  dec_pc,
    input  logic [UOP-1:0]   dec_uop,
    input  logic             dec_br_tk,
    output logic             is_valid,
    input  logic             is_ready,
    output logic [ADDR-1:0]  is_pc,
    output logic [UOP-1:0]   is_uop,
    output logic             is_br_tk,
    output logic [SEQ_W-1:0] is_seq,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        logic [ADDR-1:0]  pc;
        logic [UOP-1:0]   uop;
        logic             br_tk;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             enq, deq;
    entry_t           wr_ent, head_ent;

    // Ready/valid come from state only: no full pass-through, no empty bypass.
    assign dec_ready = (count_q != CNT_W'(DEPTH));
    assign is_valid  = (count_q != '0);
    assign count     = count_q;

    always_comb begin
        enq    = dec_valid && dec_ready && !flush;
        deq    = is_valid && is_ready && !flush;
        wr_ent = '{pc: dec_pc, uop: dec_uop, br_tk: dec_br_tk, seq: seq_q};
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        seq_d   = seq_q;
        if (flush) begin
            // seq keeps running so tags stay unique across the flush
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
                seq_d  = seq_q + SEQ_W'(1);
            end
            if (deq) head_d = head_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            seq_q   <= seq_d;
        end
    end

    // Storage is not reset; outputs below are gated while empty.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= wr_ent;
    end

    always_comb begin
        head_ent = mem_q[head_q];
        is_pc    = is_valid ? head_ent.pc    : '0;
        is_uop   = is_valid ? head_ent.uop   : '0;
        is_br_tk = is_valid ? head_ent.br_tk : 1'b0;
        is_seq   = is_valid ? head_ent.seq   : '0;
    end

    a_count_max: assert property (@(posedge clk) disable iff (!reset_)
        count_q <= CNT_W'(DEPTH));

    a_head_stable: assert property (@(posedge clk) disable iff (!reset_)
        (is_valid && !is_ready && !flush) |=>
        $stable({is_pc, is_uop, is_br_tk, is_seq}));

    a_dec_hold: assert property (@(posedge clk) disable iff (!reset_)
        (dec_valid && !dec_ready && !flush) |=>
        (dec_valid && $stable({dec_pc, dec_uop, dec_br_tk})));

endmodule
